// File: rtl/sha3_multi_slicer.sv
// Multi-channel SHA3/SHAKE message slicer. Each slot holds one message.
// Messages are cut into rate-sized blocks and sent out with round-robin channel order.
module sha3_multi_slicer #(
  parameter int NUM_CH  = 8,
  parameter int DATA_W  = 6400,
  parameter int LEN_W   = 13,
  parameter int BLOCK_W = 1344,
  parameter int BLEN_W  = 11,
  parameter int RATE0   = 1088,
  parameter int RATE1   = 576,
  parameter int RATE2   = 1344,
  parameter int RATE3   = 1088,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CH_W-1:0]    in_ch,
  input  logic [1:0]         in_mode,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [LEN_W-1:0]   in_len,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CH_W-1:0]    out_ch,
  output logic [1:0]         out_mode,
  output logic [BLEN_W-1:0]  out_rate,
  output logic [BLOCK_W-1:0] out_data,
  output logic [BLEN_W-1:0]  out_len,
  output logic               out_first,
  output logic               out_last,
  output logic [NUM_CH-1:0]  busy
);

  function automatic logic [BLEN_W-1:0] rate_of(input logic [1:0] m);
    case (m)
      2'd0:    rate_of = BLEN_W'(RATE0);
      2'd1:    rate_of = BLEN_W'(RATE1);
      2'd2:    rate_of = BLEN_W'(RATE2);
      default: rate_of = BLEN_W'(RATE3);
    endcase
  endfunction

  logic                slot_busy_reg  [NUM_CH];
  logic [1:0]          slot_mode_reg  [NUM_CH];
  logic [BLEN_W-1:0]   slot_rate_reg  [NUM_CH];
  logic [LEN_W-1:0]    slot_rem_reg   [NUM_CH];
  logic                slot_first_reg [NUM_CH];
  logic [DATA_W-1:0]   slot_data_reg  [NUM_CH];

  logic [CH_W-1:0]     last_grant_reg;
  logic [CH_W-1:0]     grant_ch;
  logic [CH_W-1:0]     cand;
  logic                grant_any;
  logic                accept;
  logic                load_en;
  logic                grant_fire;
  logic [LEN_W-1:0]    sat_len;

  logic [LEN_W-1:0]    g_rem;
  logic [BLEN_W-1:0]   g_rate;
  logic                g_full;
  logic [LEN_W-1:0]    cut_shift;
  logic [BLEN_W-1:0]   cut_len;
  logic [BLOCK_W-1:0]  cut_mask;
  logic [BLOCK_W-1:0]  cut_data;

  assign in_ready   = !busy[in_ch];
  assign accept     = in_valid && in_ready;
  assign load_en    = !out_valid || out_ready;
  assign grant_fire = load_en && grant_any;
  assign sat_len    = (in_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : in_len;

  // Descending offsets so the closest busy slot after last_grant wins.
  always_comb begin
    grant_any = 1'b0;
    grant_ch  = '0;
    cand      = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = last_grant_reg + CH_W'(k);
      if (slot_busy_reg[cand]) begin
        grant_any = 1'b1;
        grant_ch  = cand;
      end
    end
  end

  assign g_rem     = slot_rem_reg[grant_ch];
  assign g_rate    = slot_rate_reg[grant_ch];
  assign g_full    = g_rem >= LEN_W'(g_rate);
  assign cut_shift = g_full ? (g_rem - LEN_W'(g_rate)) : '0;
  assign cut_len   = g_full ? g_rate : g_rem[BLEN_W-1:0];
  assign cut_mask  = ~({BLOCK_W{1'b1}} << cut_len);
  assign cut_data  = BLOCK_W'(slot_data_reg[grant_ch] >> cut_shift) & cut_mask;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
      assign busy[gi] = slot_busy_reg[gi];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          slot_busy_reg[gi]  <= 1'b0;
          slot_mode_reg[gi]  <= '0;
          slot_rate_reg[gi]  <= '0;
          slot_rem_reg[gi]   <= '0;
          slot_first_reg[gi] <= 1'b0;
        end else if (accept && in_ch == CH_W'(gi)) begin
          slot_busy_reg[gi]  <= 1'b1;
          slot_mode_reg[gi]  <= in_mode;
          slot_rate_reg[gi]  <= rate_of(in_mode);
          slot_rem_reg[gi]   <= sat_len;
          slot_first_reg[gi] <= 1'b1;
        end else if (grant_fire && grant_ch == CH_W'(gi)) begin
          slot_first_reg[gi] <= 1'b0;
          if (g_full) slot_rem_reg[gi] <= g_rem - LEN_W'(g_rate);
          else        slot_busy_reg[gi] <= 1'b0;
        end
      end

      // Payload is only meaningful while busy, so it needs no reset.
      always_ff @(posedge clk) begin
        if (accept && in_ch == CH_W'(gi)) slot_data_reg[gi] <= in_data;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_ch         <= '0;
      out_mode       <= '0;
      out_rate       <= '0;
      out_data       <= '0;
      out_len        <= '0;
      out_first      <= 1'b0;
      out_last       <= 1'b0;
      last_grant_reg <= CH_W'(NUM_CH - 1);
    end else if (load_en) begin
      if (grant_any) begin
        out_valid      <= 1'b1;
        out_ch         <= grant_ch;
        out_mode       <= slot_mode_reg[grant_ch];
        out_rate       <= g_rate;
        out_data       <= cut_data;
        out_len        <= cut_len;
        out_first      <= slot_first_reg[grant_ch];
        out_last       <= !g_full;
        last_grant_reg <= grant_ch;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sha3_multi_slicer.sv
// Randomised and directed bench for sha3_multi_slicer; expected blocks come from
// a bit-serial message model kept in per-channel queues.
module tb_sha3_multi_slicer;
  localparam int NUM_CH = 8, DATA_W = 6400, LEN_W = 13, BLOCK_W = 1344, BLEN_W = 11, CH_W = 3;

  logic               clk, rst;
  logic               in_valid, in_ready;
  logic [CH_W-1:0]    in_ch;
  logic [1:0]         in_mode;
  logic [DATA_W-1:0]  in_data;
  logic [LEN_W-1:0]   in_len;
  logic               out_valid, out_ready;
  logic [CH_W-1:0]    out_ch;
  logic [1:0]         out_mode;
  logic [BLEN_W-1:0]  out_rate;
  logic [BLOCK_W-1:0] out_data;
  logic [BLEN_W-1:0]  out_len;
  logic               out_first, out_last;
  logic [NUM_CH-1:0]  busy;

  sha3_multi_slicer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
    .in_mode(in_mode), .in_data(in_data), .in_len(in_len), .out_valid(out_valid),
    .out_ready(out_ready), .out_ch(out_ch), .out_mode(out_mode), .out_rate(out_rate),
    .out_data(out_data), .out_len(out_len), .out_first(out_first), .out_last(out_last),
    .busy(busy)
  );

  typedef struct {
    logic [BLOCK_W-1:0] data;
    int len;
    int mode;
    int rate;
    bit first;
    bit last;
  } blk_t;

  blk_t exp_q [NUM_CH][$];
  int   got_ch[$];
  int   total = 0;
  int   bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic int rate_of(input int m);
    case (m)
      0: return 1088;
      1: return 576;
      2: return 1344;
      default: return 1088;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_data(input string tag, input logic [BLOCK_W-1:0] obs, input logic [BLOCK_W-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed(low64)=%h expected(low64)=%h", tag, obs[63:0], expv[63:0]);
    end
  endtask

  // Message bit i (i=0 earliest) sits at d[L-1-i]; block k carries bits k*R onward,
  // earliest bit in the block's top valid position.
  task automatic model_push(input int ch, input int mode, input logic [DATA_W-1:0] d, input int len);
    int L, R, n, blen;
    blk_t b;
    L = (len > DATA_W) ? DATA_W : len;
    R = rate_of(mode);
    n = L / R;
    for (int k = 0; k <= n; k++) begin
      blen = (k < n) ? R : L - n * R;
      b.data = '0;
      for (int j = 0; j < blen; j++) b.data[blen-1-j] = d[L-1-(k*R+j)];
      b.len = blen; b.mode = mode; b.rate = R;
      b.first = (k == 0); b.last = (k == n);
      exp_q[ch].push_back(b);
    end
  endtask

  task automatic check_block();
    blk_t e;
    got_ch.push_back(int'(out_ch));
    if (exp_q[out_ch].size() == 0) begin
      chk("unexpected_block_ch", longint'(out_ch), -1);
    end else begin
      e = exp_q[out_ch].pop_front();
      $display("block ch=%0d len=%0d first=%0d last=%0d mode=%0d", out_ch, out_len, out_first, out_last, out_mode);
      chk_data("blk_data", out_data, e.data);
      chk("blk_len", longint'(out_len), e.len);
      chk("blk_mode", longint'(out_mode), e.mode);
      chk("blk_rate", longint'(out_rate), e.rate);
      chk("blk_first", longint'(out_first), longint'(e.first));
      chk("blk_last", longint'(out_last), longint'(e.last));
    end
  endtask

  // Inputs are set before the call; sampling happens on the falling edge.
  task automatic tick();
    @(negedge clk);
    if (out_valid && out_ready) check_block();
    if (in_valid && in_ready) model_push(int'(in_ch), int'(in_mode), in_data, int'(in_len));
    @(posedge clk);
    #1;
  endtask

  function automatic int pending();
    int s = 0;
    for (int c = 0; c < NUM_CH; c++) s += exp_q[c].size();
    return s;
  endfunction

  task automatic send(input int ch, input int mode, input int len);
    in_valid = 1'b1;
    in_ch    = CH_W'(ch);
    in_mode  = 2'(mode);
    in_len   = LEN_W'(len);
    in_data  = rand_data();
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while ((pending() != 0 || busy != '0 || out_valid) && n < limit) begin
      tick();
      n++;
    end
    chk("drain_timeout", longint'(n >= limit), 0);
  endtask

  initial begin
    logic [BLOCK_W-1:0] snap_data;
    int snap_len, snap_ch, snap_first;
    int exp_ord[7] = '{0, 3, 0, 3, 0, 3, 0};

    rst = 1'b1; in_valid = 1'b0; in_ch = '0; in_mode = '0; in_data = '0; in_len = '0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_out_len", longint'(out_len), 0);
    chk_data("rst_out_data", out_data, '0);
    chk("rst_in_ready", longint'(in_ready), 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Two blocks from mode 0, len 2000; first out_valid one cycle after accept.
    out_ready = 1'b1;
    send(0, 0, 2000);
    chk("lat_accept_edge", longint'(out_valid), 0);
    tick();
    chk("lat_next_edge", longint'(out_valid), 1);
    chk("lat_busy0", longint'(busy[0]), 1);
    drain(50);

    // Exact multiple of rate and zero length.
    send(1, 1, 1152);
    send(2, 2, 0);
    drain(50);

    // Interleaving with a mid-message stall.
    got_ch.delete();
    send(0, 2, 4032);
    send(3, 1, 1700);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    snap_data = out_data; snap_len = int'(out_len); snap_ch = int'(out_ch); snap_first = int'(out_first);
    chk("stall_valid", longint'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_data("stall_data", out_data, snap_data);
      chk("stall_len", longint'(out_len), snap_len);
      chk("stall_ch", longint'(out_ch), snap_ch);
      chk("stall_first", longint'(out_first), snap_first);
    end
    drain(60);
    for (int i = 0; i < 7; i++) chk("rr_order", (got_ch.size() > i) ? got_ch[i] : 99, exp_ord[i]);
    chk("rr_count", got_ch.size(), 7);

    // Oversized length saturates.
    send(5, 3, 7000);
    drain(60);

    // Reset in the middle of a message.
    send(2, 0, 3000);
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #2;
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_out_last", longint'(out_last), 0);
    for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    send(2, 0, 1500);
    drain(50);

    // Random traffic with random backpressure.
    for (int cyc = 0; cyc < 600; cyc++) begin
      int m, r, sel, len;
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) == 0);
      m   = $urandom_range(0, 3);
      r   = rate_of(m);
      sel = $urandom_range(0, 4);
      case (sel)
        0: len = 0;
        1: len = r * $urandom_range(1, 4);
        2: len = $urandom_range(6400, 8000);
        default: len = $urandom_range(0, 6400);
      endcase
      in_ch   = CH_W'($urandom_range(0, NUM_CH - 1));
      in_mode = 2'(m);
      in_len  = LEN_W'(len);
      in_data = rand_data();
      tick();
    end
    drain(2000);
    chk("final_pending", pending(), 0);
    chk("final_busy", longint'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
